// File: rtl/fifo_frame_rd_ctrl.sv
// Read-side frame controller for the audio sample FIFO.
// Waits until the FIFO read water level holds a full frame. It then reads
// exactly FRAME_LEN words and streams them out over valid/ready. A 2-entry
// buffer absorbs the one-cycle FIFO read latency and downstream stalls.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   enable              permits new frames to start (a running frame always completes)
//   fifo_rd_data        FIFO read data, valid the cycle after an accepted read
//   fifo_empty          FIFO empty flag
//   fifo_rd_water_level FIFO read-side fill level
//   fifo_rd_en          FIFO read enable (combinational)
//   m_data/m_valid/m_ready/m_first/m_last  sample stream with frame markers
//   busy                frame in progress
//   frame_done          one-cycle pulse after the last beat of a frame is accepted
//   frame_cnt           completed frames, wrapping
module fifo_frame_rd_ctrl #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAME_LEN  = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   input  logic [ADDR_WIDTH:0]   fifo_rd_water_level,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_first,
   output logic                  m_last,
   output logic                  busy,
   output logic                  frame_done,
   output logic [15:0]           frame_cnt
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] LEN    = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(FRAME_LEN - 1);

   // A one-beat frame would need first and last on the same beat.
   if (FRAME_LEN < 4 || FRAME_LEN > (1 << ADDR_WIDTH)) begin : g_bad_frame_len
      $error("fifo_frame_rd_ctrl: FRAME_LEN out of range");
   end

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  first;
      logic                  last;
   } entry_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   issue_cnt_q;
   logic [CNT_W-1:0]   beat_cnt_q;
   logic               inflight_q;
   logic [1:0]         occ_q;
   entry_t             head_q, tail_q;
   entry_t             cap;
   logic               busy_q;
   logic               frame_done_q;
   logic [15:0]        frame_cnt_q;
   logic               pop;
   logic               rd_en;
   logic               start;
   logic               last_pop;
   logic [2:0]         level_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and FIFO read enable
   always_comb begin
      state_d  = state_q;
      rd_en    = 1'b0;
      start    = 1'b0;
      last_pop = 1'b0;
      pop      = (occ_q != 2'd0) && m_ready;
      // Buffer slots committed next cycle if nothing new is read now.
      level_c  = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
      case (state_q)
         IDLE: begin
            if (enable && (fifo_rd_water_level >= LEN)) begin
               start   = 1'b1;
               state_d = BURST;
            end
         end
         BURST: begin
            rd_en = !fifo_empty && (issue_cnt_q < LEN) && (level_c < 3'd2);
            if (rd_en && (issue_cnt_q == LEN_M1)) state_d = DRAIN;
         end
         DRAIN: begin
            last_pop = pop && (beat_cnt_q == LEN_M1);
            if (last_pop) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Word arriving from the FIFO; issue_cnt already counts it, so it is
   // beat issue_cnt of the frame.
   always_comb begin
      cap       = '0;
      cap.data  = fifo_rd_data;
      cap.first = (issue_cnt_q == CNT_W'(1));
      cap.last  = (issue_cnt_q == LEN);
   end

   // Counters, read tracking and status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt_q  <= '0;
         beat_cnt_q   <= '0;
         inflight_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         inflight_q   <= rd_en;
         busy_q       <= (state_d != IDLE);
         frame_done_q <= last_pop;
         if (last_pop) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (start) begin
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
         end else begin
            if (rd_en) issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            if (pop)   beat_cnt_q  <= beat_cnt_q + CNT_W'(1);
         end
      end
   end

   // Two-entry output buffer; head only changes on a pop or when empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         case ({inflight_q, pop})
            2'b10: begin
               if (occ_q == 2'd0) head_q <= cap;
               else               tail_q <= cap;
               occ_q <= occ_q + 2'd1;
            end
            2'b01: begin
               head_q <= (occ_q == 2'd2) ? tail_q : '0;
               occ_q  <= occ_q - 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd1) head_q <= cap;
               else begin
                  head_q <= tail_q;
                  tail_q <= cap;
               end
            end
            default: ;
         endcase
      end
   end

   assign fifo_rd_en = rd_en;
   assign m_data     = head_q.data;
   assign m_first    = head_q.first;
   assign m_last     = head_q.last;
   assign m_valid    = (occ_q != 2'd0);
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/fifo_frame_rd_ctrl.md
# fifo_frame_rd_ctrl

Read-side controller for the audio sample FIFO (fifo_ambition: ADDR_WIDTH 10, DATA_WIDTH 16, no output register). It drains the FIFO in fixed-length frames for the FFT/FIR front end. A frame starts only once the read water level holds a complete frame. The block streams that frame over a valid/ready interface with first/last markers and a 2-entry output buffer, so downstream backpressure never drops or duplicates a sample.

## Interface
- ADDR_WIDTH, 10, FIFO address width; water level is ADDR_WIDTH+1 bits
- DATA_WIDTH, 16, sample width
- FRAME_LEN, 256, samples per frame; legal range 4 .. 2**ADDR_WIDTH
- clk  input  1  single clock, same clock as FIFO rd_clk
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  level; permits new frames to start
- fifo_rd_data  input  DATA_WIDTH  FIFO rd_data, valid the cycle after an accepted read
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_water_level  input  ADDR_WIDTH+1  FIFO read water level
- fifo_rd_en  output  1  FIFO read enable (combinational)
- m_data  output  DATA_WIDTH  sample out
- m_valid  output  1  sample valid
- m_ready  input  1  downstream accept
- m_first  output  1  qualifies the first beat of a frame
- m_last  output  1  qualifies beat FRAME_LEN of a frame
- busy  output  1  high in BURST or DRAIN
- frame_done  output  1  one-cycle pulse after the last beat is accepted
- frame_cnt  output  16  completed frames, wraps at 2**16

## Operation
- FSM states:
  - IDLE -> BURST when enable && fifo_rd_water_level >= FRAME_LEN; issue_cnt and beat_cnt are cleared on entry.
  - BURST -> DRAIN when the read that makes issue_cnt reach FRAME_LEN is issued.
  - DRAIN -> IDLE on the handshake (m_valid && m_ready) of beat FRAME_LEN.
- Output buffer: 2 entries, FIFO order. Head drives m_data, m_first and m_last.
- inflight: 1 if fifo_rd_en was high last cycle and fifo_empty was low, else 0.
- pop = m_valid && m_ready.
- fifo_rd_en = (state==BURST) && !fifo_empty && issue_cnt<FRAME_LEN && (occ + inflight - pop) < 2. Each cycle that fifo_rd_en is high with fifo_empty low increments issue_cnt.
- Entering BURST requires a full frame in the level, so fifo_empty should never block. If it does, reads stall and resume; no data is lost.
- The FIFO word captured after an in-flight read is written into the buffer. That entry is tagged first if it is beat 1 and last if it is beat FRAME_LEN.
- beat_cnt increments on each pop.
- m_data, m_first and m_last are held stable while m_valid && !m_ready.
- Deasserting enable mid-frame does not abort: the frame completes, then the FSM stays in IDLE.
- frame_done pulses and frame_cnt increments in the cycle after the last pop.
- Reset: all outputs 0, state IDLE, buffer empty, all counters 0.
- Reset asserted mid-frame: the partial frame is discarded immediately. Words already read from the FIFO are lost; FIFO contents are not touched.

## Timing
- The start condition is sampled at rising edge E. fifo_rd_en is high in the cycle following E.
- Read issued in cycle c -> fifo_rd_data valid in c+1 -> captured at the end of c+1 -> m_valid high in c+2.
- With m_ready constantly 1:
  - fifo_rd_en is high for FRAME_LEN consecutive cycles.
  - m_valid is high for FRAME_LEN consecutive cycles.
  - frame_done pulses 1 cycle after the last beat.
- Minimum gap between frames: the FSM spends 1 cycle in IDLE, then 2 cycles of read latency. That gives 3 idle output cycles between the last beat of one frame and the first beat of the next.
- occ + inflight never exceeds 2 in any cycle.
- m_first and m_last are asserted together only if FRAME_LEN is 1, which is illegal. FRAME_LEN >= 4 is therefore enforced.

## Test plan
- Reset: hold rst_n low with FIFO level 1024 -> all outputs 0; release with enable=0 -> fifo_rd_en stays 0 indefinitely.
- Threshold: FRAME_LEN=256, write 255 samples (1..255) -> no fifo_rd_en. Write sample 256 -> exactly 256 reads, m_data 1..256 in order, m_first on 1, m_last on 256, one frame_done, frame_cnt=1.
- Backpressure: 512 samples, 50% random m_ready -> 2 frames, data 1..512 with no gaps or duplicates, m_data stable during stalls, occ+inflight <= 2 every cycle.
- Enable drop: deassert enable at beat 100 of frame 1 with 768 samples buffered -> frame 1 completes all 256 beats, no second frame until enable returns.
- Reset mid-frame: assert rst_n low at beat 50 -> outputs 0 the same cycle. Re-enable -> next frame begins with the first FIFO word not yet read, m_first set.
- Back-to-back: write 1024 samples, m_ready=1 -> 4 frames, frame_cnt=4, exactly 3 idle output cycles between frames, FIFO empty at end.
